// File: rtl/serial_adder_param.sv
// Multi-cycle adder: adds two WIDTH-bit operands DIGIT_W bits per clock, LSB digit first.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` input that inverts B on accept.
module serial_adder_param #(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready depends only on state, and the result is held until out_ready is seen.
    generate
        if (WIDTH < 1 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_params
            $error("serial_adder_param: WIDTH must be >= 1 and a multiple of DIGIT_W");
        end
    endgenerate

    localparam int NDIG = WIDTH / DIGIT_W;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   b_eff;
    logic               carry_q;
    logic [IW-1:0]      dig_base;
    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [DIGIT_W-1:0] s_dig;
    logic               c_dig;
    logic               msb_cin;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
`else
    assign b_eff = b;
`endif

    assign in_ready = (state == IDLE);

    // One DIGIT_W-wide full-adder slice shared by every digit.
    always_comb begin
        dig_base = IW'(cnt) * IW'(DIGIT_W);
        a_dig    = a_q[dig_base +: DIGIT_W];
        b_dig    = b_q[dig_base +: DIGIT_W];
        {c_dig, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_W{1'b0}}, carry_q};
        // Carry into the top bit of this digit, recovered from its sum bit.
        msb_cin  = a_dig[DIGIT_W-1] ^ b_dig[DIGIT_W-1] ^ s_dig[DIGIT_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= carry_in;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum[dig_base +: DIGIT_W] <= s_dig;
                    carry_q <= c_dig;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        carry_out <= c_dig;
                        overflow  <= msb_cin ^ c_dig;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_param.sv
// Bench for serial_adder_param: an 8x1 and a 16x4 instance checked against an arithmetic model.
module tb_serial_adder_param;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  out_ready;
    logic [1:0]  cin_v;
    logic [1:0]  sub_v;
    logic [15:0] a_v [2];
    logic [15:0] b_v [2];
    wire  [1:0]  in_ready;
    wire  [1:0]  out_valid;
    wire  [1:0]  cout_v;
    wire  [1:0]  ovf_v;
    wire  [7:0]  sum8;
    wire  [15:0] sum16;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int rdy_mode [2] = '{2, 2};   // 0 random, 1 hold low, 2 hold high

    // Model: phase per instance plus the result predicted at accept time.
    int          m_state [2];     // 0 idle, 1 running, 2 result held
    int          m_left  [2];
    logic [15:0] m_sum   [2];
    logic        m_cout  [2];
    logic        m_ovf   [2];

    serial_adder_param #(.WIDTH(8), .DIGIT_W(1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_v[0]),
`endif
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .carry_in(cin_v[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum8),
        .carry_out(cout_v[0]), .overflow(ovf_v[0])
    );

    serial_adder_param #(.WIDTH(16), .DIGIT_W(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub_v[1]),
`endif
        .a(a_v[1]), .b(b_v[1]), .carry_in(cin_v[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum16),
        .carry_out(cout_v[1]), .overflow(ovf_v[1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(int d);
        return (d != 0) ? 16 : 8;
    endfunction

    function automatic int ndig(int d);
        return (d != 0) ? 4 : 8;
    endfunction

    function automatic logic [15:0] get_sum(int d);
        return (d != 0) ? sum16 : {8'h00, sum8};
    endfunction

    task automatic chk(string name, int d, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, d, got, exp, $time);
        end
    endtask

    // Unsigned and signed sums of the effective operands, straight from the arithmetic rules.
    task automatic predict(int d);
        longint one  = 1;
        longint w    = longint'(wid(d));
        longint mask = (one << w) - 1;
        longint av   = longint'(a_v[d]) & mask;
        longint bv   = longint'(b_v[d]) & mask;
        longint tot, sa, sb, st;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub_v[d]) bv = ~bv & mask;
`endif
        tot = av + bv + longint'(cin_v[d]);
        m_sum[d]  = 16'(tot & mask);
        m_cout[d] = ((tot >> w) & 1) != 0;
        sa = (av >= (one << (w - 1))) ? av - (one << w) : av;
        sb = (bv >= (one << (w - 1))) ? bv - (one << w) : bv;
        st = sa + sb + longint'(cin_v[d]);
        m_ovf[d] = (st > (one << (w - 1)) - 1) || (st < -(one << (w - 1)));
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_state[d] = 0;
                m_left[d]  = 0;
            end else begin
                case (m_state[d])
                    0: if (in_valid[d]) begin
                        predict(d);
                        m_left[d]  = ndig(d);
                        m_state[d] = 1;
                    end
                    1: begin
                        m_left[d]--;
                        if (m_left[d] == 0) m_state[d] = 2;
                    end
                    default: if (out_ready[d]) m_state[d] = 0;
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    chk("rst_in_ready", d, 32'(in_ready[d]), 32'd1);
                    chk("rst_out_valid", d, 32'(out_valid[d]), 32'd0);
                    chk("rst_sum", d, 32'(get_sum(d)), 32'd0);
                end else begin
                    chk("in_ready", d, 32'(in_ready[d]), 32'(m_state[d] == 0));
                    chk("out_valid", d, 32'(out_valid[d]), 32'(m_state[d] == 2));
                    if (m_state[d] == 2) begin
                        chk("sum", d, 32'(get_sum(d)), 32'(m_sum[d]));
                        chk("carry_out", d, 32'(cout_v[d]), 32'(m_cout[d]));
                        chk("overflow", d, 32'(ovf_v[d]), 32'(m_ovf[d]));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            case (rdy_mode[d])
                0:       out_ready[d] = ($urandom_range(0, 3) != 0);
                1:       out_ready[d] = 1'b0;
                default: out_ready[d] = 1'b1;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(int d, logic [15:0] a, logic [15:0] b, logic c, logic s);
        int n = 0;
        @(negedge clk);
        a_v[d] = a;
        b_v[d] = b;
        cin_v[d] = c;
        sub_v[d] = s;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", d, 32'(n), 32'd0);
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(int d);
        int n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", d, 32'(n), 32'd0);
    endtask

    task automatic wait_valid(int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 64) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic lit(string name, int d, logic [15:0] a, logic [15:0] b, logic c, logic s,
                       logic [15:0] es, logic ec, logic eo);
        int lat;
        rdy_mode[d] = 1;
        send(d, a, b, c, s);
        wait_valid(d, lat);
        chk({name, "_latency"}, d, 32'(lat), 32'(ndig(d)));
        chk({name, "_sum"}, d, 32'(get_sum(d)), 32'(es));
        chk({name, "_cout"}, d, 32'(cout_v[d]), 32'(ec));
        chk({name, "_ovf"}, d, 32'(ovf_v[d]), 32'(eo));
        rdy_mode[d] = 2;
        wait_idle(d);
    endtask

    task automatic rand_ops(int d, int n);
        rdy_mode[d] = 0;
        repeat (n) begin
            send(d, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode[d] = 2;
        wait_idle(d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = '0;
        cin_v = '0;
        sub_v = '0;
        for (int d = 0; d < 2; d++) begin
            a_v[d] = '0;
            b_v[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_in_ready", d, 32'(in_ready[d]), 32'd1);
            chk("reset_out_valid", d, 32'(out_valid[d]), 32'd0);
            chk("reset_sum", d, 32'(get_sum(d)), 32'd0);
            chk("reset_cout", d, 32'(cout_v[d]), 32'd0);
            chk("reset_ovf", d, 32'(ovf_v[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        lit("ff_plus_01", 0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0);
        lit("7f_plus_01", 0, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1);
        lit("80_plus_80", 0, 16'h80, 16'h80, 1'b1, 1'b0, 16'h01, 1'b1, 1'b1);

        // Backpressure: result must hold while new operands are offered.
        rdy_mode[0] = 1;
        send(0, 16'h3C, 16'h5A, 1'b0, 1'b0);
        wait_valid(0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid[0] = 1'(i % 2);
            a_v[0] = 16'($urandom);
            b_v[0] = 16'($urandom);
            chk("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
            chk("bp_sum", 0, 32'(sum8), 32'h96);
            chk("bp_ovf", 0, 32'(ovf_v[0]), 32'd1);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        rdy_mode[0] = 2;
        wait_idle(0);

        // Asynchronous reset in the middle of a run.
        send(0, 16'hAA, 16'h55, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("abort_sum", 0, 32'(sum8), 32'd0);
        chk("abort_cout", 0, 32'(cout_v[0]), 32'd0);
        chk("abort_ovf", 0, 32'(ovf_v[0]), 32'd0);
        chk("abort_in_ready", 0, 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lit("after_abort", 0, 16'h12, 16'h34, 1'b0, 1'b0, 16'h46, 1'b0, 1'b0);

        lit("ffff_cin", 1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        lit("sub_05_07", 0, 16'h05, 16'h07, 1'b1, 1'b1, 16'hFE, 1'b0, 1'b0);
        lit("sub_80_01", 0, 16'h80, 16'h01, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1);
`endif

        fork
            rand_ops(0, 200);
            rand_ops(1, 1000);
        join

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_param.md
Name: serial_adder_param

Overview:
- Parametrised multi-cycle adder with a `DIGIT_W`-bit full-adder slice.
- Adds two `WIDTH`-bit operands plus a carry-in over `WIDTH/DIGIT_W` clock cycles, least-significant digit first.
- Used where area matters more than latency.
- Upstream and downstream use valid/ready handshakes; result is held until consumed.

Parameters:
- `WIDTH`, 8, operand/result width in bits; must be a multiple of `DIGIT_W`.
- `DIGIT_W`, 1, bits added per cycle (1 = bit-serial, `WIDTH` = single-cycle ripple).

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  operands valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  `WIDTH`  operand A.
- `b`  input  `WIDTH`  operand B.
- `carry_in`  input  1  initial carry.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts result.
- `sum`  output  `WIDTH`  result.
- `carry_out`  output  1  final carry out of MSB.
- `overflow`  output  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - One clock `clk`; `rst_n` asynchronous, active-low. Assertion immediately forces `state`=`IDLE`.
  - `out_valid`=0, `sum`=0, `carry_out`=0, `overflow`=0, digit counter=0, carry register=0, operand registers=0.
  - `in_ready`=1 while in reset and after release.
- `NDIG` = `WIDTH/DIGIT_W`; counter width = `clog2(NDIG)`, minimum 1.
- States:
  - `IDLE`: `in_ready`=1. On `in_valid`&`in_ready` at an edge: latch `a`, `b`, `carry_in`; counter=0; go to `RUN`.
  - `RUN`: `in_ready`=0. Each edge adds digit[counter] of A, B and the carry register.
    - Writes `DIGIT_W` sum bits into `sum`[counter*`DIGIT_W` +: `DIGIT_W`].
    - Updates carry register; counter increments.
    - On the edge processing digit `NDIG`-1: set `carry_out` = final carry, `overflow` = carry into MSB XOR carry out of MSB, `out_valid`=1; go to `DONE`.
  - `DONE`: `in_ready`=0. `sum`/`carry_out`/`overflow` stable while `out_valid`=1. On `out_valid`&`out_ready` at an edge: `out_valid`=0; go to `IDLE`.
- Latency: `out_valid` rises `NDIG` edges after the accepting edge. Throughput: one operation per `NDIG`+2 cycles minimum (no overlap; `in_ready` is purely `state`==`IDLE`).
- `sum` accumulates in place during `RUN`. Intermediate values are visible but undefined for consumers.
- `in_valid` while not `IDLE` is ignored; upstream holds per protocol.
- `out_ready` outside `DONE` is ignored.
- Arithmetic is modulo 2^`WIDTH`; overflow per signed rule above. Result equals `{carry_out,sum}` = `a`+`b`+`carry_in` for every parameter legal combination.
- Reset mid-`RUN` or mid-`DONE`: operation aborted, no result emitted, all outputs to reset values.
- Illegal parameters (`WIDTH` % `DIGIT_W` != 0, or `WIDTH`<1) stop elaboration via generate-time error.

Optional Feature:
- Macro `SERIAL_ADDER_SUB_EN`.
- Defined:
  - Extra input port `sub` (1 bit), sampled with operands on accept.
  - When `sub`=1, B is bitwise-inverted on latch, so result = `a` + ~`b` + `carry_in`. Caller drives `carry_in`=1 for `a`-`b`.
  - `carry_out`=1 means no borrow; `overflow` computed on the effective operands.
- Not defined: port absent; behaviour is addition only, identical to `sub`=0.

Test Plan:
- `WIDTH`=8, `DIGIT_W`=1: accept `a`=0xFF, `b`=0x01, `carry_in`=0 -> `out_valid` 8 edges after accept; `sum`=0x00, `carry_out`=1, `overflow`=0; `in_ready`=1 the cycle after `out_ready` handshake.
- `WIDTH`=8, `DIGIT_W`=1: `a`=0x7F, `b`=0x01, `carry_in`=0 -> `sum`=0x80, `carry_out`=0, `overflow`=1; `a`=0x80, `b`=0x80, `carry_in`=1 -> `sum`=0x01, `carry_out`=1, `overflow`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in `DONE`, toggle `in_valid` with new operands -> outputs unchanged, `in_ready`=0 throughout, new operands not accepted until `IDLE`.
- Reset abort: assert `rst_n`=0 asynchronously after 3 `RUN` cycles -> `out_valid`, `sum`, `carry_out`, `overflow` immediately 0, `in_ready`=1; next operation `a`=0x12, `b`=0x34 gives `sum`=0x46 correctly.
- `WIDTH`=16, `DIGIT_W`=4: `a`=0xFFFF, `b`=0x0000, `carry_in`=1 -> latency 4 edges, `sum`=0x0000, `carry_out`=1, `overflow`=0; random 1000 vectors match `a`+`b`+`carry_in`.
- `SERIAL_ADDER_SUB_EN` defined, `WIDTH`=8: `a`=0x05, `b`=0x07, `sub`=1, `carry_in`=1 -> `sum`=0xFE, `carry_out`=0, `overflow`=0; `a`=0x80, `b`=0x01, `sub`=1, `carry_in`=1 -> `sum`=0x7F, `carry_out`=1, `overflow`=1.
